// File: rtl/read_addr_scheduler_if.sv
// AR-side request, engine command and R-channel monitor bundle for read_addr_scheduler.
// The slave modport is the scheduler; master is whoever drives the AR requests and the engine.
interface read_addr_scheduler_if #(
    parameter int ADD_WIDTH    = 32,
    parameter int ADD_ID_WIDTH = 3,
    parameter int BURST_LEN    = 4,
    parameter int BURST_SIZE   = 3,
    parameter int BURST_TYPE   = 2,
    parameter int DEPTH        = 4
);
    logic [ADD_WIDTH-1:0]      araddr;
    logic [BURST_LEN-1:0]      arlen;
    logic [BURST_SIZE-1:0]     arsize;
    logic [BURST_TYPE-1:0]     arburst;
    logic [ADD_ID_WIDTH-1:0]   arid;
    logic                      arvalid;
    logic                      arready;

    logic [ADD_WIDTH-1:0]      raddr_out;
    logic [BURST_LEN-1:0]      rlen_out;
    logic [BURST_SIZE-1:0]     rsize_out;
    logic [BURST_TYPE-1:0]     rburst_out;
    logic [ADD_ID_WIDTH-1:0]   rid_out;
    logic                      mod1_valid_out;
    logic                      mod1_ready_in;

    logic                      rvalid;
    logic                      rready;
    logic                      rlast;

    logic                      busy;
    logic [$clog2(DEPTH):0]    occupancy;

    modport master (
        output araddr, arlen, arsize, arburst, arid, arvalid,
        output mod1_ready_in, rvalid, rready, rlast,
        input  arready, raddr_out, rlen_out, rsize_out, rburst_out, rid_out,
        input  mod1_valid_out, busy, occupancy
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arid, arvalid,
        input  mod1_ready_in, rvalid, rready, rlast,
        output arready, raddr_out, rlen_out, rsize_out, rburst_out, rid_out,
        output mod1_valid_out, busy, occupancy
    );
endinterface

// File: rtl/read_addr_scheduler.sv
// Queues AR requests and hands them to the read burst engine one burst at a time.
//   state | meaning
//   IDLE  | nothing issued, waiting for a queued request
//   ISSUE | head presented to the engine (mod1_valid_out high) until accepted
//   BUSY  | burst accepted, waiting for the R beat with rlast to handshake
module read_addr_scheduler #(
    parameter int ADD_WIDTH    = 32,
    parameter int ADD_ID_WIDTH = 3,
    parameter int BURST_LEN    = 4,
    parameter int BURST_SIZE   = 3,
    parameter int BURST_TYPE   = 2,
    parameter int DEPTH        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    read_addr_scheduler_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADD_WIDTH + BURST_LEN + BURST_SIZE + BURST_TYPE + ADD_ID_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t             state;
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               arready_q;
    logic               valid_q;
    logic               busy_q;
    logic               push;
    logic               pop;
    logic               rlast_hs;

    assign push     = bus.arvalid && arready_q;
    assign pop      = (state == ISSUE) && bus.mod1_ready_in;
    assign rlast_hs = bus.rvalid && bus.rready && bus.rlast;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arid};
        end
    end

    // arready looks at the post-update count, so a pop from a full FIFO frees a slot only next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            arready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_next;
            arready_q <= (count_next != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state   <= ISSUE;
                        valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.mod1_ready_in) begin
                        state   <= BUSY;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (rlast_hs) begin
                        busy_q <= 1'b0;
                        if (count_next != '0) begin
                            state   <= ISSUE;
                            valid_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign {bus.raddr_out, bus.rlen_out, bus.rsize_out, bus.rburst_out, bus.rid_out} = fifo_mem[rd_ptr];
    assign bus.arready        = arready_q;
    assign bus.mod1_valid_out = valid_q;
    assign bus.busy           = busy_q;
    assign bus.occupancy      = count;
endmodule

// File: tb/tb_read_addr_scheduler.sv
// Bench for read_addr_scheduler: directed scenarios plus a randomized run against a queue-based model.
module tb_read_addr_scheduler;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  id;
    } ar_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // model: queued requests, whether a command is being presented, whether a burst is outstanding
    ar_t  q[$];
    bit   m_present  = 1'b0;
    bit   m_inflight = 1'b0;
    bit   m_arready  = 1'b0;

    always #5 clk = ~clk;

    read_addr_scheduler_if #(.ADD_WIDTH(32), .ADD_ID_WIDTH(3), .BURST_LEN(4),
                             .BURST_SIZE(3), .BURST_TYPE(2), .DEPTH(DEPTH)) bus ();

    read_addr_scheduler #(.ADD_WIDTH(32), .ADD_ID_WIDTH(3), .BURST_LEN(4),
                          .BURST_SIZE(3), .BURST_TYPE(2), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic clear_inputs();
        bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arid = '0;
        bus.arvalid = 1'b0; bus.mod1_ready_in = 1'b0;
        bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [2:0] id);
        bus.araddr = a; bus.arlen = l; bus.arsize = s; bus.arburst = b; bus.arid = id;
        bus.arvalid = 1'b1;
    endtask

    task automatic set_r(input logic v);
        bus.rvalid = v; bus.rready = v; bus.rlast = v;
    endtask

    // advance one clock and update the model from the inputs applied during that cycle
    task automatic tick();
        ar_t e;
        bit  push, pop, done;
        int  pre_size;
        e        = {bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arid};
        push     = (bus.arvalid === 1'b1) && m_arready;
        pop      = m_present && (bus.mod1_ready_in === 1'b1);
        done     = m_inflight && (bus.rvalid === 1'b1) && (bus.rready === 1'b1) && (bus.rlast === 1'b1);
        pre_size = q.size();
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_present  = 1'b0;
            m_inflight = 1'b0;
            m_arready  = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            if (m_present) begin
                m_inflight = pop;
                m_present  = !pop;
            end else if (m_inflight) begin
                m_inflight = !done;
                m_present  = done && (q.size() != 0);
            end else begin
                m_present = (pre_size != 0);
            end
            m_arready = (q.size() != DEPTH);
        end
        #1;
    endtask

    task automatic drain();
        int n = 0;
        clear_inputs();
        while ((q.size() != 0 || m_present || m_inflight) && n < 200) begin
            bus.mod1_ready_in = 1'b1;
            set_r(m_inflight);
            tick();
            n++;
        end
        clear_inputs();
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout occupancy=%0d required drained", bus.occupancy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        checks++;
        if ({bus.arready, bus.mod1_valid_out, bus.busy} !== 3'b000 || bus.occupancy !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got arready=%b valid=%b busy=%b occ=%0d required all 0",
                     bus.arready, bus.mod1_valid_out, bus.busy, bus.occupancy);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.arready !== 1'b1) begin
            errors++; $display("FAIL arready_after_reset got %b required 1", bus.arready);
        end
    endtask

    task automatic test_single();
        set_ar(32'h100, 4'd3, 3'd2, 2'd1, 3'd2);
        tick();
        bus.arvalid = 1'b0;
        checks++;
        if (bus.occupancy !== 3'd1 || bus.mod1_valid_out !== 1'b0) begin
            errors++; $display("FAIL single_queued got occ=%0d valid=%b required 1/0", bus.occupancy, bus.mod1_valid_out);
        end
        tick();
        checks++;
        if (bus.mod1_valid_out !== 1'b1 || bus.raddr_out !== 32'h100 || bus.rid_out !== 3'd2 || bus.rlen_out !== 4'd3) begin
            errors++;
            $display("FAIL single_issue got valid=%b addr=%h id=%0d len=%0d required 1/100/2/3",
                     bus.mod1_valid_out, bus.raddr_out, bus.rid_out, bus.rlen_out);
        end
        bus.mod1_ready_in = 1'b1;
        tick();
        bus.mod1_ready_in = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.mod1_valid_out !== 1'b0 || bus.occupancy !== 3'd0) begin
            errors++; $display("FAIL single_accept got busy=%b valid=%b occ=%0d required 1/0/0",
                               bus.busy, bus.mod1_valid_out, bus.occupancy);
        end
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL single_hold_busy got %b required 1", bus.busy);
        end
        set_r(1'b1);
        tick();
        set_r(1'b0);
        checks++;
        if (bus.busy !== 1'b0 || bus.mod1_valid_out !== 1'b0) begin
            errors++; $display("FAIL single_done got busy=%b valid=%b required 0/0", bus.busy, bus.mod1_valid_out);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            set_ar(32'h1000 + 32'(i * 16), 4'(i), 3'd2, 2'd1, 3'(i));
            tick();
        end
        checks++;
        if (bus.occupancy !== 3'd4 || bus.arready !== 1'b0) begin
            errors++; $display("FAIL fill_full got occ=%0d arready=%b required 4/0", bus.occupancy, bus.arready);
        end
        set_ar(32'h2000, 4'd7, 3'd3, 2'd2, 3'd7);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.occupancy !== 3'd4 || bus.arready !== 1'b0 || bus.rid_out !== 3'd0) begin
                errors++; $display("FAIL fill_fifth_held got occ=%0d arready=%b head_id=%0d required 4/0/0",
                                   bus.occupancy, bus.arready, bus.rid_out);
            end
        end
    endtask

    task automatic test_full_pop_push();
        bus.mod1_ready_in = 1'b1;
        tick();
        bus.mod1_ready_in = 1'b0;
        checks++;
        if (bus.occupancy !== 3'd3 || bus.arready !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL full_pop_no_push got occ=%0d arready=%b busy=%b required 3/1/1",
                               bus.occupancy, bus.arready, bus.busy);
        end
        tick();
        bus.arvalid = 1'b0;
        checks++;
        if (bus.occupancy !== 3'd4 || bus.arready !== 1'b0) begin
            errors++; $display("FAIL full_refill got occ=%0d arready=%b required 4/0", bus.occupancy, bus.arready);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 3; k++) begin
            set_ar(32'h300 + 32'(k), 4'(k), 3'd1, 2'd1, 3'(k));
            tick();
        end
        bus.arvalid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            int n = 0;
            while (bus.mod1_valid_out !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (bus.mod1_valid_out !== 1'b1 || bus.rid_out !== 3'(k) || bus.raddr_out !== 32'h300 + 32'(k) || bus.busy !== 1'b0) begin
                errors++; $display("FAIL b2b_issue_%0d got valid=%b id=%0d addr=%h busy=%b required 1/%0d/%h/0",
                                   k, bus.mod1_valid_out, bus.rid_out, bus.raddr_out, bus.busy, k, 32'h300 + k);
            end
            bus.mod1_ready_in = 1'b1;
            tick();
            bus.mod1_ready_in = 1'b0;
            tick();
            tick();
            checks++;
            if (bus.mod1_valid_out !== 1'b0 || bus.busy !== 1'b1) begin
                errors++; $display("FAIL b2b_wait_rlast_%0d got valid=%b busy=%b required 0/1", k, bus.mod1_valid_out, bus.busy);
            end
            set_r(1'b1);
            tick();
            set_r(1'b0);
            checks++;
            if (bus.mod1_valid_out !== (k < 3) || bus.busy !== 1'b0) begin
                errors++; $display("FAIL b2b_after_rlast_%0d got valid=%b busy=%b required %0d/0",
                                   k, bus.mod1_valid_out, bus.busy, k < 3);
            end
        end
    endtask

    task automatic test_spurious();
        set_r(1'b1);
        tick();
        tick();
        set_r(1'b0);
        checks++;
        if (bus.busy !== 1'b0 || bus.mod1_valid_out !== 1'b0 || bus.occupancy !== 3'd0 || bus.arready !== 1'b1) begin
            errors++; $display("FAIL spurious_idle got busy=%b valid=%b occ=%0d arready=%b required 0/0/0/1",
                               bus.busy, bus.mod1_valid_out, bus.occupancy, bus.arready);
        end
        set_ar(32'h500, 4'd5, 3'd0, 2'd0, 3'd5);
        tick();
        bus.arvalid = 1'b0;
        tick();
        set_r(1'b1);
        tick();
        set_r(1'b0);
        checks++;
        if (bus.mod1_valid_out !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL spurious_issue got valid=%b busy=%b required 1/0", bus.mod1_valid_out, bus.busy);
        end
        bus.mod1_ready_in = 1'b1;
        tick();
        bus.mod1_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++; $display("FAIL spurious_not_counted got busy=%b required 1", bus.busy);
            end
        end
        set_r(1'b1);
        tick();
        set_r(1'b0);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL spurious_own_rlast got busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_reset_busy();
        for (int k = 0; k < 3; k++) begin
            set_ar(32'h700 + 32'(k * 4), 4'd1, 3'd2, 2'd1, 3'(k));
            tick();
        end
        bus.arvalid = 1'b0;
        bus.mod1_ready_in = 1'b1;
        tick();
        bus.mod1_ready_in = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.occupancy !== 3'd2) begin
            errors++; $display("FAIL rstbusy_setup got busy=%b occ=%0d required 1/2", bus.busy, bus.occupancy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.occupancy !== 3'd0 || {bus.busy, bus.mod1_valid_out, bus.arready} !== 3'b000) begin
            errors++; $display("FAIL rstbusy_flush got occ=%0d busy=%b valid=%b arready=%b required 0/0/0/0",
                               bus.occupancy, bus.busy, bus.mod1_valid_out, bus.arready);
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.arready !== 1'b1 || bus.mod1_valid_out !== 1'b0) begin
            errors++; $display("FAIL rstbusy_recover got arready=%b valid=%b required 1/0", bus.arready, bus.mod1_valid_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            checks++;
            if (bus.arready !== m_arready) begin
                errors++; $display("FAIL rand_arready cyc=%0d got %b required %b", c, bus.arready, m_arready);
            end
            checks++;
            if (bus.mod1_valid_out !== m_present) begin
                errors++; $display("FAIL rand_valid cyc=%0d got %b required %b", c, bus.mod1_valid_out, m_present);
            end
            checks++;
            if (bus.busy !== m_inflight) begin
                errors++; $display("FAIL rand_busy cyc=%0d got %b required %b", c, bus.busy, m_inflight);
            end
            checks++;
            if (bus.occupancy !== 3'(q.size())) begin
                errors++; $display("FAIL rand_occupancy cyc=%0d got %0d required %0d", c, bus.occupancy, q.size());
            end
            if (m_present && q.size() != 0) begin
                checks++;
                if ({bus.raddr_out, bus.rlen_out, bus.rsize_out, bus.rburst_out, bus.rid_out} !== q[0]) begin
                    errors++; $display("FAIL rand_head cyc=%0d got addr=%h id=%0d required addr=%h id=%0d",
                                       c, bus.raddr_out, bus.rid_out, q[0].addr, q[0].id);
                end
            end
            bus.araddr  = $urandom();
            bus.arlen   = 4'($urandom());
            bus.arsize  = 3'($urandom());
            bus.arburst = 2'($urandom());
            bus.arid    = 3'($urandom());
            bus.arvalid = ($urandom_range(0, 99) < 45);
            bus.mod1_ready_in = ($urandom_range(0, 99) < 40);
            bus.rvalid  = ($urandom_range(0, 99) < 60);
            bus.rready  = ($urandom_range(0, 99) < 70);
            bus.rlast   = ($urandom_range(0, 99) < 35);
            tick();
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop_push();
        test_back_to_back();
        test_spurious();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
